// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Brief    : RV32I memory-access + writeback stage with req/ack data bus,
//            wait-state stalling, timeout abort and optional misalign check
//            (enable with `define MISALIGN_CHECK_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int              CNT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_abort;
    logic [1:0]  w_a;
    logic [3:0]  w_store_be;
    logic [31:0] w_store_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_result;

    assign w_mem_op = MemReadM | MemWriteM;
    assign w_a      = ALU_ResultM[1:0];

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        if (w_mem_op) begin
            case (Funct3M[1:0])
                2'b01:   w_misaligned = w_a[0];
                2'b10:   w_misaligned = |w_a;
                default: w_misaligned = 1'b0;
            endcase
        end
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // Request is masked by reset so it drops the instant rst rises.
    assign dmem_req  = ~rst & w_mem_op & ~w_misaligned;
    assign w_abort   = (r_state == ST_WAIT) & ~dmem_ack & (r_cnt == CNT_MAX);
    assign StallM    = dmem_req & ~dmem_ack & ~w_abort;
    assign dmem_addr = {ALU_ResultM[31:2], 2'b00};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            // The issuing IDLE cycle already counts as one un-acked cycle,
            // so the request is held at most WAIT_MAX+1 cycles in total.
            if (w_next_state == ST_WAIT)
                r_cnt <= (r_state == ST_IDLE) ? CNT_ONE : r_cnt + CNT_ONE;
            else
                r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (dmem_req && !dmem_ack)  w_next_state = ST_WAIT;
            ST_WAIT: if (dmem_ack || w_abort)    w_next_state = ST_IDLE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: bus lanes and load extraction
    // ------------------------------------------------------------------
    always_comb begin
        w_store_be   = 4'b1111;
        w_store_data = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_store_be   = 4'b0001 << w_a;
                w_store_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_store_be   = w_a[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_store_be   = 4'b1111;
                w_store_data = WriteDataM;
            end
        endcase

        dmem_we    = dmem_req & MemWriteM;
        dmem_be    = MemWriteM ? w_store_be : 4'b1111;
        dmem_wdata = w_store_data;

        case (w_a)
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (Funct3M)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata;
        endcase

        case (ResultSrcM)
            2'b01:   w_result = w_load_data;
            2'b10:   w_result = PCPlus4M;
            default: w_result = ALU_ResultM;
        endcase
    end

    // ------------------------------------------------------------------
    // M/W pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW    <= 1'b0;
            RDW          <= 5'd0;
            ResultW      <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            bus_err      <= w_abort;
            misalign_err <= w_misaligned;
            if (StallM) begin
                // Bubble so the older instruction is not written again.
                RegWriteW <= 1'b0;
            end else begin
                RegWriteW <= RegWriteM & (RD_M != 5'd0) & ~w_abort & ~w_misaligned;
                RDW       <= RD_M;
                ResultW   <= w_result;
            end
        end
    end

endmodule

`default_nettype wire
